// File: rtl/key_loader.sv
// key_loader: serial CRC-8 protected key loader for a logic-locked netlist.
module key_loader #(
  parameter int KEY_W          = 32,
  parameter int MAX_FAIL       = 3,
  parameter int LOCK_ON_COMMIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             s_valid,
  input  logic             s_data,
  output logic             s_ready,
  output logic [KEY_W-1:0] key_out,
  output logic             key_valid,
  output logic             busy,
  output logic             crc_err,
  output logic             locked
);
  localparam int CW = $clog2(KEY_W + 9);
  localparam int FW = $clog2(MAX_FAIL + 1);
  typedef enum logic [2:0] {IDLE, SHIFT_KEY, SHIFT_CRC, CHECK, DONE, LOCKOUT} state_t;
  state_t            state, state_nx;
  logic [CW-1:0]     cnt;
  logic [FW-1:0]     fail_cnt;
  logic [KEY_W-1:0]  shadow;
  logic [7:0]        crc, rx_crc, crc_nx;
  logic              xfer, restart, match, last_fail;
  always_comb begin
    s_ready   = state == SHIFT_KEY || state == SHIFT_CRC;
    busy      = s_ready || state == CHECK;
    locked    = state == LOCKOUT;
    match     = rx_crc == crc;
    crc_err   = state == CHECK && !match;
    restart   = start && (state == IDLE || s_ready);
    xfer      = s_ready && s_valid && !start;
    last_fail = fail_cnt >= FW'(MAX_FAIL - 1);
    crc_nx    = {crc[6:0], 1'b0} ^ ((crc[7] ^ s_data) ? 8'h07 : 8'h00);
    state_nx  = state;
    if (restart) state_nx = SHIFT_KEY;
    else if (xfer && state == SHIFT_KEY && cnt == CW'(KEY_W - 1)) state_nx = SHIFT_CRC;
    else if (xfer && state == SHIFT_CRC && cnt == CW'(7)) state_nx = CHECK;
    else if (state == CHECK)
      state_nx = match ? ((LOCK_ON_COMMIT != 0) ? DONE : IDLE) : (last_fail ? LOCKOUT : IDLE);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt       <= '0;
      fail_cnt  <= '0;
      shadow    <= '0;
      crc       <= '0;
      rx_crc    <= '0;
      key_out   <= '0;
      key_valid <= 1'b0;
    end else begin
      if (restart) begin
        cnt    <= '0;
        shadow <= '0;
        crc    <= '0;
        rx_crc <= '0;
      end else if (xfer) begin
        cnt <= (state_nx != state) ? '0 : cnt + 1'b1;
        if (state == SHIFT_KEY) begin
          shadow <= (shadow & ~(KEY_W'(1) << cnt)) | (KEY_W'(s_data) << cnt);
          crc    <= crc_nx;
        end else rx_crc <= {rx_crc[6:0], s_data};
      end
      if (state == CHECK && match) begin
        key_out   <= shadow;
        key_valid <= 1'b1;
        fail_cnt  <= '0;
      end else if (crc_err) begin
        if (fail_cnt != FW'(MAX_FAIL)) fail_cnt <= fail_cnt + 1'b1;
        // lockout scrubs the committed key so the netlist stays locked
        if (last_fail) begin
          key_out   <= '0;
          key_valid <= 1'b0;
        end
      end
    end
endmodule

// File: tb/tb_key_loader.sv
// tb_key_loader: directed checks of key_loader (commit-lock and reloadable instances).
module tb_key_loader;
  logic        clk = 0, rst_n = 0, start = 0, s_valid = 0, s_data = 0;
  logic        s_ready_a, key_valid_a, busy_a, crc_err_a, locked_a;
  logic        s_ready_b, key_valid_b, busy_b, crc_err_b, locked_b;
  logic [31:0] key_out_a, key_out_b;
  logic        rdy;
  bit          sel = 0;
  int          checks = 0, errors = 0, xfers = 0, errp_a = 0, errp_b = 0;
  logic [31:0] k, k1, k2;
  int          x0, e0;

  key_loader u_a (.clk(clk), .rst_n(rst_n), .start(start), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready_a), .key_out(key_out_a), .key_valid(key_valid_a), .busy(busy_a),
    .crc_err(crc_err_a), .locked(locked_a));
  key_loader #(.LOCK_ON_COMMIT(0)) u_b (.clk(clk), .rst_n(rst_n), .start(start), .s_valid(s_valid),
    .s_data(s_data), .s_ready(s_ready_b), .key_out(key_out_b), .key_valid(key_valid_b),
    .busy(busy_b), .crc_err(crc_err_b), .locked(locked_b));

  always #5 clk = ~clk;
  assign rdy = sel ? s_ready_b : s_ready_a;

  always @(posedge clk) begin
    if (s_valid && rdy) xfers++;
    if (crc_err_a) errp_a++;
    if (crc_err_b) errp_b++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] crc8(input logic [31:0] key);
    logic [7:0] c = 8'h00;
    for (int i = 0; i < 32; i++) c = {c[6:0], 1'b0} ^ ((c[7] ^ key[i]) ? 8'h07 : 8'h00);
    return c;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; start = 0; s_valid = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
  endtask

  task automatic send_bit(input logic b, input bit gaps);
    int tries = 0;
    do begin
      @(negedge clk);
      s_data = b;
      s_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      tries++;
    end while (!(s_valid && rdy) && tries < 50);
    if (!(s_valid && rdy)) chk("xfer_timeout", 0, 1);
    @(posedge clk); #1;
    s_valid = 0;
  endtask

  task automatic send_key(input logic [31:0] key, input int n, input bit gaps);
    for (int i = 0; i < n; i++) send_bit(key[i], gaps);
  endtask

  task automatic send_crc(input logic [7:0] c, input int n, input bit gaps);
    for (int i = 7; i > 7 - n; i--) send_bit(c[i], gaps);
  endtask

  task automatic send_frame(input logic [31:0] key, input logic [7:0] c, input bit gaps);
    send_key(key, 32, gaps);
    send_crc(c, 8, gaps);
  endtask

  task automatic fail_frame_b();
    pulse_start();
    send_frame(32'h0, 8'h01, 0);
    chk("b_fail_crc_err", crc_err_b, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    do_reset();
    #1;
    chk("rst_key_out", key_out_a, 0);
    chk("rst_key_valid", key_valid_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_s_ready", s_ready_a, 0);
    chk("rst_locked", locked_a, 0);
    chk("rst_crc_err", crc_err_a, 0);

    // zero key, zero CRC, commit then DONE ignores start
    sel = 0;
    pulse_start();
    chk("z_busy", busy_a, 1);
    chk("z_ready", s_ready_a, 1);
    send_frame(32'h0, 8'h00, 0);
    chk("z_check_busy", busy_a, 1);
    chk("z_check_ready", s_ready_a, 0);
    chk("z_check_err", crc_err_a, 0);
    chk("z_check_kv", key_valid_a, 0);
    @(posedge clk); #1;
    chk("z_kv", key_valid_a, 1);
    chk("z_key", key_out_a, 0);
    chk("z_done_busy", busy_a, 0);
    pulse_start();
    chk("z_start_ignored", busy_a, 0);
    chk("z_done_ready", s_ready_a, 0);

    // random key with gappy valid, 40 transfers
    do_reset();
    k = $urandom;
    x0 = xfers;
    pulse_start();
    send_frame(k, crc8(k), 1);
    @(posedge clk); #1;
    chk("r_key", key_out_a, k);
    chk("r_kv", key_valid_a, 1);
    chk("r_xfers", xfers - x0, 40);

    // three bad CRCs lock out
    do_reset();
    e0 = errp_a;
    for (int n = 1; n <= 3; n++) begin
      pulse_start();
      send_frame(32'h0, 8'h01, 0);
      chk("l_crc_err", crc_err_a, 1);
      @(posedge clk); #1;
      chk("l_err_one_cycle", crc_err_a, 0);
      chk("l_locked", locked_a, n == 3);
    end
    chk("l_pulses", errp_a - e0, 3);
    chk("l_key", key_out_a, 0);
    chk("l_kv", key_valid_a, 0);
    chk("l_ready", s_ready_a, 0);
    pulse_start();
    chk("l_start_ignored", busy_a, 0);

    // reloadable instance: fail count clears on commit, key updates only at CHECK
    do_reset();
    sel = 1;
    k1 = 32'hDEAD_BEEF;
    k2 = 32'h1234_5678;
    fail_frame_b();
    fail_frame_b();
    chk("b_not_locked", locked_b, 0);
    pulse_start();
    send_frame(k1, crc8(k1), 0);
    chk("b_pre_commit", key_out_b, 0);
    @(posedge clk); #1;
    chk("b_key1", key_out_b, k1);
    chk("b_kv1", key_valid_b, 1);
    chk("b_idle", busy_b, 0);
    pulse_start();
    send_key(k2, 20, 0);
    chk("b_mid_key", key_out_b, k1);
    chk("b_mid_kv", key_valid_b, 1);
    send_key(k2 >> 20, 12, 0);
    send_crc(crc8(k2), 8, 0);
    chk("b_check_key", key_out_b, k1);
    @(posedge clk); #1;
    chk("b_key2", key_out_b, k2);
    chk("b_kv2", key_valid_b, 1);
    fail_frame_b();
    fail_frame_b();
    chk("b_count_cleared", locked_b, 0);
    chk("b_key_kept", key_out_b, k2);
    chk("b_kv_kept", key_valid_b, 1);
    fail_frame_b();
    chk("b_locked", locked_b, 1);
    chk("b_lock_key", key_out_b, 0);
    chk("b_lock_kv", key_valid_b, 0);

    // abort after 10 key bits, with a valid bit in the start cycle
    do_reset();
    sel = 0;
    k = 32'hC0FF_EE11;
    e0 = errp_a;
    pulse_start();
    send_key(32'hFFFF_FFFF, 10, 0);
    @(negedge clk); start = 1; s_valid = 1; s_data = 1;
    @(negedge clk); start = 0; s_valid = 0;
    send_frame(k, crc8(k), 0);
    chk("a_check_err", crc_err_a, 0);
    @(posedge clk); #1;
    chk("a_key", key_out_a, k);
    chk("a_kv", key_valid_a, 1);
    chk("a_no_err", errp_a - e0, 0);

    // async reset mid-CRC after a commit, then a fresh load
    do_reset();
    sel = 1;
    k = 32'h0BAD_F00D;
    pulse_start();
    send_frame(k, crc8(k), 0);
    @(posedge clk); #1;
    chk("x_key", key_out_b, k);
    pulse_start();
    send_key(32'h5555_AAAA, 32, 0);
    send_crc(crc8(32'h5555_AAAA), 3, 0);
    #2 rst_n = 0;
    #1;
    chk("x_key_rst", key_out_b, 0);
    chk("x_kv_rst", key_valid_b, 0);
    chk("x_busy_rst", busy_b, 0);
    chk("x_ready_rst", s_ready_b, 0);
    chk("x_err_rst", crc_err_b, 0);
    chk("x_locked_rst", locked_b, 0);
    @(negedge clk); rst_n = 1;
    k = 32'h8000_0001;
    pulse_start();
    send_frame(k, crc8(k), 0);
    @(posedge clk); #1;
    chk("x_fresh_key", key_out_b, k);
    chk("x_fresh_kv", key_valid_b, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/key_loader.md
KEY_LOADER -- requirements
Module: key_loader

Interface
REQ-001 SHALL have parameter KEY_W, default 32, which sets the key width driving the keyinput0..keyinput(KEY_W-1) ports of the locked netlist.
REQ-002 SHALL have parameter MAX_FAIL, default 3, which sets the number of consecutive checksum failures before permanent lockout.
REQ-003 SHALL have parameter LOCK_ON_COMMIT, default 1; when set to 1, further loads are refused after the first successful commit.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1 bit: a one-cycle pulse that begins or restarts a load frame.
REQ-007 SHALL have port s_valid, input, 1 bit: serial bit valid.
REQ-008 SHALL have port s_data, input, 1 bit: serial key/CRC bit.
REQ-009 SHALL have port s_ready, output, 1 bit: loader accepts a serial bit this cycle.
REQ-010 SHALL have port key_out, output, KEY_W bits: committed key, bit i drives keyinput<i>.
REQ-011 SHALL have port key_valid, output, 1 bit: key_out holds a checksum-verified key.
REQ-012 SHALL have port busy, output, 1 bit: a frame is in progress.
REQ-013 SHALL have port crc_err, output, 1 bit: one-cycle pulse on checksum mismatch.
REQ-014 SHALL have port locked, output, 1 bit: lockout after MAX_FAIL consecutive failures.

Function
REQ-015 SHALL treat a serial bit as transferred only in cycles where s_valid and s_ready are both 1.
REQ-016 SHALL frame each load as KEY_W key bits (bit 0 first), then 8 CRC bits (CRC[7] first).
REQ-017 SHALL implement states IDLE, SHIFT_KEY, SHIFT_CRC, CHECK, DONE and LOCKOUT.
REQ-018 SHALL, in IDLE, move to SHIFT_KEY on start, clear the bit counter, shadow register and CRC register, and keep s_ready=0.
REQ-019 SHALL, in SHIFT_KEY, assert s_ready=1, write each transferred bit into shadow[count], and go to SHIFT_CRC after transfer KEY_W.
REQ-020 SHALL compute the running CRC over key bits only, using CRC-8 with polynomial 0x07 and init 0x00: fb=crc[7]^bit; crc={crc[6:0],1'b0}^(fb?8'h07:8'h00).
REQ-021 SHALL, in SHIFT_CRC, assert s_ready=1, shift the 8 received bits into rx_crc MSB-first, and go to CHECK after the 8th transfer.
REQ-022 SHALL spend exactly one cycle in CHECK with s_ready=0 and compare rx_crc to the computed CRC.
REQ-023 SHALL, on a CRC match, load key_out from shadow on the CHECK clock edge, set key_valid=1, clear the fail counter, and go to DONE if LOCK_ON_COMMIT=1 or to IDLE otherwise.
REQ-024 SHALL, on a CRC mismatch, pulse crc_err for one cycle, leave key_out/key_valid unchanged, increment the fail counter, and go to LOCKOUT if the count reaches MAX_FAIL or to IDLE otherwise.
REQ-025 SHALL, in DONE, ignore start and hold s_ready=0, with key_out held until reset.
REQ-026 SHALL, in LOCKOUT, set locked=1, set s_ready=0, ignore start, and force key_out to 0 with key_valid=0 until reset.
REQ-027 SHALL, on a start during SHIFT_KEY or SHIFT_CRC, abort the frame and restart at SHIFT_KEY with counters and CRC cleared, not count the abort as a failure, and discard any bit in that cycle.
REQ-028 SHALL never change key_out except at a CRC-match commit, on entry to LOCKOUT, or on reset.
REQ-029 SHALL assert busy=1 in SHIFT_KEY, SHIFT_CRC and CHECK, and busy=0 otherwise.
REQ-030 SHALL size the bit counter to hold KEY_W without wrap; the counter SHALL NOT advance on cycles with no transfer.
REQ-031 SHALL limit the fail counter to MAX_FAIL and SHALL NOT let it wrap.

Reset
REQ-032 SHALL, on rst_n=0 at any time including mid-frame, immediately set: state IDLE, key_out=0, key_valid=0, s_ready=0, busy=0, crc_err=0, locked=0, and clear all counters and the shadow register.
REQ-033 SHALL leave IDLE only on the first rising clk edge with rst_n=1 and start=1.

Verification
REQ-034 SHALL be covered by: start, key 0x00000000, CRC 0x00 -> key_valid=1 one cycle after the last CRC bit, key_out=0, DONE, and a later start ignored.
REQ-035 SHALL be covered by: a random key with the reference-model CRC, s_valid toggled randomly -> key_out equals the key, with exactly 40 transfers counted.
REQ-036 SHALL be covered by: key 0x00000000 with CRC 0x01, repeated 3 times -> crc_err pulses 3 times, locked=1 after the 3rd CHECK, key_out=0, s_ready=0.
REQ-037 SHALL be covered by: 2 failures then a good frame (LOCK_ON_COMMIT=0), then a new good frame -> the fail count clears, key_out updates only at each CHECK, and key_valid stays 1.
REQ-038 SHALL be covered by: start reasserted after 10 key bits, then a full good frame -> only the second frame is committed, with no crc_err.
REQ-039 SHALL be covered by: rst_n dropped mid-SHIFT_CRC after a prior commit -> all outputs zero asynchronously, and a fresh load succeeds.
